turn_timer: RTL and testbench

//  Per-turn countdown for TicTacToe; directly upstream of Turnos, whose timeOut input it drives.

---
 rtl/tictactoe_pkg.sv | 10 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/turn_timer.sv | 108 ++++++++++
 tb/tb_turn_timer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared TicTacToe types and constants
package tictactoe_pkg;

    typedef enum logic [1:0] {TT_IDLE, TT_RUN, TT_EXPIRED} turn_timer_state_t;

    typedef enum logic [1:0] {CELL_EMPTY, CELL_X, CELL_O} cell_t;

    localparam int TT_TURN_SECS = 15;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running 0..CLK_HZ-1 counter producing a one-second tick
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn countdown driving Turnos.timeOut
// Optional low-time warn output enabled by TURN_TIMER_WARN_EN.
module turn_timer
    import tictactoe_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TURN_SECS = TT_TURN_SECS,
    localparam int SW       = $clog2(TURN_SECS + 1)
`ifdef TURN_TIMER_WARN_EN
    ,
    parameter int WARN_SECS = 5
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          game_active,
    input  logic          colocado,
    output logic          time_out,
    output logic [SW-1:0] secs_left,
    output logic          running
`ifdef TURN_TIMER_WARN_EN
    ,
    output logic          warn
`endif
);

    localparam logic [SW-1:0] FULL = SW'(TURN_SECS);
    localparam logic [SW-1:0] ONE  = SW'(1);
`ifdef TURN_TIMER_WARN_EN
    localparam logic [SW-1:0] WARN_AT = SW'(WARN_SECS);
`endif

    turn_timer_state_t state;
    logic              tick;
    logic              pre_clr;

    // Prescaler restarts whenever the turn restarts or the timer is not counting.
    assign pre_clr = !game_active || (state != TT_RUN) || colocado;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (state == TT_RUN),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= TT_IDLE;
            secs_left <= FULL;
            time_out  <= 1'b0;
            running   <= 1'b0;
`ifdef TURN_TIMER_WARN_EN
            warn      <= 1'b0;
`endif
        end else begin
            time_out <= 1'b0;
`ifdef TURN_TIMER_WARN_EN
            warn     <= 1'b0;
`endif
            if (!game_active) begin
                state     <= TT_IDLE;
                secs_left <= FULL;
                running   <= 1'b0;
            end else begin
                case (state)
                    TT_IDLE: begin
                        state     <= TT_RUN;
                        secs_left <= FULL;
                        running   <= 1'b1;
                    end
                    TT_RUN: begin
                        // A placement beats a coincident final tick.
                        if (colocado) begin
                            secs_left <= FULL;
                        end else if (tick) begin
                            if (secs_left > ONE) begin
                                secs_left <= secs_left - ONE;
`ifdef TURN_TIMER_WARN_EN
                                warn      <= (secs_left - ONE) <= WARN_AT;
`endif
                            end else begin
                                secs_left <= '0;
                                state     <= TT_EXPIRED;
                                time_out  <= 1'b1;
                            end
                        end else begin
`ifdef TURN_TIMER_WARN_EN
                            warn <= warn;
`endif
                        end
                    end
                    TT_EXPIRED: begin
                        state     <= TT_RUN;
                        secs_left <= FULL;
                    end
                    default: begin
                        state     <= TT_IDLE;
                        secs_left <= FULL;
                        running   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_turn_timer.sv
// tb/tb_turn_timer.sv - self-checking bench for turn_timer (CLK_HZ=4, TURN_SECS=3, WARN_SECS=1)
module tb_turn_timer;

    localparam int CLK_HZ    = 4;
    localparam int TURN_SECS = 3;
    localparam int WARN_SECS = 1;
    localparam int SW        = $clog2(TURN_SECS + 1);
    localparam int PERIOD    = TURN_SECS * CLK_HZ;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          game_active = 1'b0;
    logic          colocado = 1'b0;
    logic          time_out;
    logic [SW-1:0] secs_left;
    logic          running;
`ifdef TURN_TIMER_WARN_EN
    logic          warn;
`endif

    turn_timer #(
        .CLK_HZ    (CLK_HZ),
        .TURN_SECS (TURN_SECS)
`ifdef TURN_TIMER_WARN_EN
        ,
        .WARN_SECS (WARN_SECS)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_active (game_active),
        .colocado    (colocado),
        .time_out    (time_out),
        .secs_left   (secs_left),
`ifdef TURN_TIMER_WARN_EN
        .warn        (warn),
`endif
        .running     (running)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: cycles elapsed in the current turn; PERIOD means the expiry cycle.
    int m_run = 0;
    int m_e   = 0;

    function automatic int m_secs();
        if (m_run == 0) return TURN_SECS;
        if (m_e == PERIOD) return 0;
        return TURN_SECS - m_e / CLK_HZ;
    endfunction

    function automatic int m_to();
        return (m_run != 0 && m_e == PERIOD) ? 1 : 0;
    endfunction

    function automatic int warn_of(input int run, input int secs);
        return (run != 0 && secs <= WARN_SECS && secs != 0) ? 1 : 0;
    endfunction

    task automatic m_step(input logic ga, input logic col);
        if (!ga) begin
            m_run = 0; m_e = 0;
        end else if (m_run == 0) begin
            m_run = 1; m_e = 0;
        end else if (m_e == PERIOD || col) begin
            m_e = 0;
        end else begin
            m_e++;
        end
    endtask

    task automatic cycle(input logic ga, input logic col);
        game_active = ga;
        colocado    = col;
        @(posedge clk);
        #1;
        m_step(ga, col);
    endtask

    typedef struct {
        logic ga;
        logic col;
        int   secs;
        int   to;
        int   run;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic ga, input logic col, input int secs, input int to,
                       input int run, input int n);
        vec_t v;
        v.ga = ga; v.col = col; v.secs = secs; v.to = to; v.run = run;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        // Idle, then free expiry: 3,2,1 every 4 cycles, time_out 12 cycles after first RUN cycle
        add(0, 0, 3, 0, 0, 1);
        add(1, 0, 3, 0, 1, 4);
        add(1, 0, 2, 0, 1, 4);
        add(1, 0, 1, 0, 1, 4);
        add(1, 0, 0, 1, 1, 1);
        add(1, 0, 3, 0, 1, 4);
        add(1, 0, 2, 0, 1, 4);
        add(1, 0, 1, 0, 1, 1);
        // Placement at secs_left=1, then full-length countdown proves prescaler restarted
        add(1, 1, 3, 0, 1, 1);
        add(1, 0, 3, 0, 1, 3);
        add(1, 0, 2, 0, 1, 4);
        add(1, 0, 1, 0, 1, 4);
        // Collision with the final tick
        add(1, 1, 3, 0, 1, 1);
        add(1, 0, 3, 0, 1, 3);
        add(1, 0, 2, 0, 1, 1);
        // Abort at secs_left=2; stays idle across the would-be expiry, colocado ignored
        add(0, 0, 3, 0, 0, 1);
        add(0, 1, 3, 0, 0, 13);
        // Restart, expire, colocado during EXPIRED
        add(1, 0, 3, 0, 1, 4);
        add(1, 0, 2, 0, 1, 4);
        add(1, 0, 1, 0, 1, 4);
        add(1, 0, 0, 1, 1, 1);
        add(1, 1, 3, 0, 1, 1);
        add(1, 0, 3, 0, 1, 3);
        add(1, 0, 2, 0, 1, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_secs", int'(secs_left), TURN_SECS);
        chk("reset_time_out", int'(time_out), 0);
        chk("reset_running", int'(running), 0);
`ifdef TURN_TIMER_WARN_EN
        chk("reset_warn", int'(warn), 0);
`endif
        rst = 1'b1;
        m_run = 0; m_e = 0;

        foreach (tbl[i]) begin
            cycle(tbl[i].ga, tbl[i].col);
            chk($sformatf("vec%0d_secs", i), int'(secs_left), tbl[i].secs);
            chk($sformatf("vec%0d_time_out", i), int'(time_out), tbl[i].to);
            chk($sformatf("vec%0d_running", i), int'(running), tbl[i].run);
`ifdef TURN_TIMER_WARN_EN
            chk($sformatf("vec%0d_warn", i), int'(warn), warn_of(tbl[i].run, tbl[i].secs));
`endif
        end

        // Asynchronous reset mid-count while secs_left=2
        begin
            int budget = 40;
            while (m_secs() != 2 && budget > 0) begin
                cycle(1, 0);
                budget--;
            end
            chk("async_setup_secs", int'(secs_left), 2);
        end
        #3 rst = 1'b0;
        #1;
        chk("async_rst_secs", int'(secs_left), TURN_SECS);
        chk("async_rst_running", int'(running), 0);
        chk("async_rst_time_out", int'(time_out), 0);
        @(posedge clk);
        #1;
        chk("async_hold_running", int'(running), 0);
        rst = 1'b1;
        m_run = 0; m_e = 0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic ga, col;
            ga  = ($urandom_range(0, 39) != 0);
            col = ($urandom_range(0, 11) == 0);
            cycle(ga, col);
            chk("rand_secs", int'(secs_left), m_secs());
            chk("rand_time_out", int'(time_out), m_to());
            chk("rand_running", int'(running), m_run);
`ifdef TURN_TIMER_WARN_EN
            chk("rand_warn", int'(warn), warn_of(m_run, m_secs()));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
